axis_slave_ram: RTL and testbench
=================================

// Module: axis_slave_ram
// PURPOSE
//  AXI4 slave responder backed by an internal byte-enable RAM; the far end of the vector unit's AXI4 master.
//  Accepts the master's INCR bursts (AW/W/B, AR/R; full-width beats, awlen/arlen up to 255) on the same channel subset.
//  Used as on-chip scratch memory and as the bus-functional target in system simulation.
//  Read and write paths are independent; one outstanding burst per direction.
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  32    byte address width
//  C_S_AXI_DATA_WIDTH  32    data width, power of 2, >=32
//  C_MEM_DEPTH         4096  RAM depth in data words, power of 2
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-low reset (rst==0 resets)
//  s_axi_awvalid  in   1     write address valid
//  s_axi_awready  out  1     write address ready
//  s_axi_awaddr   in   AW    write burst start byte address
//  s_axi_awlen    in   8     write beats minus one
//  s_axi_wvalid   in   1     write data valid
//  s_axi_wready   out  1     write data ready
//  s_axi_wdata    in   DW    write data
//  s_axi_wstrb    in   DW/8  byte enables
//  s_axi_wlast    in   1     last write beat
//  s_axi_bvalid   out  1     write response valid (always OKAY)
//  s_axi_bready   in   1     write response ready
//  s_axi_arvalid  in   1     read address valid
//  s_axi_arready  out  1     read address ready
//  s_axi_araddr   in   AW    read burst start byte address
//  s_axi_arlen    in   8     read beats minus one
//  s_axi_rvalid   out  1     read data valid
//  s_axi_rready   in   1     read data ready
//  s_axi_rdata    out  DW    read data
//  s_axi_rlast    out  1     last read beat
//  wlast_err      out  1     sticky: wlast mismatched beat count
// BEHAVIOUR
//  Reset (rst==0 at edge): both FSMs idle; awready=arready=1, wready=bvalid=rvalid=rlast=wlast_err=0; rdata=0; RAM contents kept.
//  Word index = addr[log2(DW/8) +: log2(C_MEM_DEPTH)]; low byte bits ignored; upper bits ignored -> addresses wrap modulo depth.
//  Index increments per beat, wraps C_MEM_DEPTH-1 -> 0 (no 4KB-boundary checking).
//  Write FSM: W_IDLE (awready=1) -aw fire-> W_DATA (awready=0, wready=1): latch index, cnt=awlen.
//   Each w fire: write bytes with wstrb=1 at index, index++, cnt--. Beat with cnt==0 -> W_RESP (wready=0, bvalid=1).
//   W_RESP -b fire-> W_IDLE. bvalid held until bready. wlast!=(cnt==0) on any beat sets wlast_err; count governs, not wlast.
//  Read FSM: R_IDLE (arready=1) -ar fire at edge k-> R_FETCH (RAM read of start index) -> R_DATA, rvalid=1 from cycle k+2.
//   RAM read address = index+1 on r fire, else index, so back-to-back beats at 1 beat/clk while rready=1.
//   rdata/rlast stable while rvalid && !rready. rlast=1 on beat cnt==0; its fire -> R_IDLE, rvalid=0 next cycle.
//  Simultaneous read and write to same word in one cycle: read returns old data (read-first).
//  wvalid before aw fire: wready=0, data not taken. New AW/AR not accepted until previous burst completes (incl. B).
//  Reset mid-burst: bursts abandoned, outputs to reset values; partially written words stay written.
// STRUCTURE
//  Package axis_slave_ram_pkg: wr_state_t {W_IDLE,W_DATA,W_RESP}, rd_state_t {R_IDLE,R_FETCH,R_DATA}, AXI_RESP_OKAY.
//  Sub-module axis_slave_ram_bram: simple dual-port RAM, 1 write port with per-byte enables, 1 sync read-first read port.
//  Top holds the two FSMs, counters, index registers and wlast_err.
// TESTING
//  AW 0x10 len 3, wdata 0xA0..0xA3, wstrb 0xF -> B after 4th beat; AR 0x10 len 3 -> rdata A0..A3, rlast on 4th, rvalid at k+2.
//  Write 0xFFFFFFFF then 0x00000000 with wstrb 0x5 to same word -> read 0xFF00FF00.
//  AR len 255 with rready toggling 1/0 pseudo-randomly -> 256 beats in order, no duplicates/drops, data stable while stalled.
//  AW len 3 with wlast on beat 2 -> wlast_err=1, 4 beats still accepted, B issued once; stays set until reset.
//  AW at last word (C_MEM_DEPTH-1) len 1 -> 2nd beat lands in word 0; readback confirms wrap.
//  rst=0 during read beat 5 of 16 and write beat 2 -> next cycle rvalid=wready=bvalid=0, awready=arready=1; new bursts work.

Source files
------------

// File: rtl/axis_slave_ram_pkg.sv
// Shared definitions for the AXI4 slave RAM.
// Holds the write and read FSM state encodings and the AXI response code.
// The states are plain localparam constants rather than enums, so that
// older tools and netlists see ordinary 2-bit vectors.
package axis_slave_ram_pkg;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;  // waiting for AW
  localparam wr_state_t W_DATA = 2'd1;  // accepting W beats
  localparam wr_state_t W_RESP = 2'd2;  // presenting B

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE  = 2'd0;  // waiting for AR
  localparam rd_state_t R_FETCH = 2'd1;  // RAM read of the first beat in flight
  localparam rd_state_t R_DATA  = 2'd2;  // presenting R beats

  // Every write response is OKAY, so the port list carries no bresp.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axis_slave_ram_bram.sv
// Simple dual-port RAM with per-byte write enables and a synchronous,
// read-first read port. If a word is read and written in the same cycle,
// the read returns the value the word had before the write.
// Ports:
//   clk    clock
//   rst    synchronous active-low reset, clears the read data register only
//   we     write enable;  waddr / wdata / wstrb give the word, data and byte lanes
//   re     read enable;   raddr gives the word, rdata holds its value until the next read
module axis_slave_ram_bram #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset. Memories map onto RAM macros that cannot
  // be cleared in one cycle, and their contents must survive a reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (we && wstrb[b]) begin
        // NOTE: use non-blocking assignment here. The read process then samples
        // the value from before this edge, which gives read-first behaviour.
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Only the output register is reset. With the enable low, it holds its
  // value, so the data stays stable while the reader stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_slave_ram.sv
// AXI4 slave backed by an internal byte-enable RAM. It accepts INCR bursts
// on the AW/W/B and AR/R channels, with full-width beats and len up to 255.
// The read and write paths are independent, and each allows one burst at a time.
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   s_axi_aw*                write address: valid/ready, start byte address, beats-1
//   s_axi_w*                 write data: valid/ready, data, byte strobes, last
//   s_axi_b*                 write response: valid/ready (always OKAY)
//   s_axi_ar*                read address: valid/ready, start byte address, beats-1
//   s_axi_r*                 read data: valid/ready, data, last
//   wlast_err                sticky flag: some wlast did not match the beat count
import axis_slave_ram_pkg::*;

module axis_slave_ram #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_DEPTH        = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            wlast_err
);

  localparam int BYTE_BITS = $clog2(C_S_AXI_DATA_WIDTH/8);
  localparam int IDX_W     = $clog2(C_MEM_DEPTH);

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [7:0]       wr_cnt, rd_cnt;

  logic             w_fire, r_fire, ram_re;
  logic [IDX_W-1:0] ram_raddr;

  // The word index drops the byte-lane bits and any bits above the RAM depth,
  // so addresses wrap modulo the depth. This fold keeps the discarded bits
  // formally read.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = (wr_state == W_IDLE);
  assign s_axi_wready  = (wr_state == W_DATA);
  assign s_axi_bvalid  = (wr_state == W_RESP);
  assign s_axi_arready = (rd_state == R_IDLE);
  assign s_axi_rvalid  = (rd_state == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid && (rd_cnt == 8'd0);

  assign w_fire = s_axi_wvalid && s_axi_wready;
  assign r_fire = s_axi_rvalid && s_axi_rready;

  // Fetch ahead. The first beat is read while in R_FETCH. The next word is
  // read on each accepted beat, except the last. While stalled, the RAM
  // output register keeps the current beat.
  // NOTE: give every always_comb output a default first, so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = rd_idx;
    if (rd_state == R_FETCH) begin
      ram_re = 1'b1;
    end else if (r_fire && rd_cnt != 8'd0) begin
      ram_re    = 1'b1;
      ram_raddr = rd_idx + IDX_W'(1);
    end
  end

  // Write FSM. The beat count decides where the burst ends. A wlast that
  // disagrees with the count only raises the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state  <= W_IDLE;
      wr_idx    <= '0;
      wr_cnt    <= '0;
      wlast_err <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (s_axi_awvalid) begin
          wr_idx   <= s_axi_awaddr[BYTE_BITS +: IDX_W];
          wr_cnt   <= s_axi_awlen;
          wr_state <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          wr_idx <= wr_idx + IDX_W'(1);
          wr_cnt <= wr_cnt - 8'd1;
          if (s_axi_wlast != (wr_cnt == 8'd0)) wlast_err <= 1'b1;
          if (wr_cnt == 8'd0) wr_state <= W_RESP;
        end
        W_RESP: if (s_axi_bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_idx   <= '0;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (s_axi_arvalid) begin
          rd_idx   <= s_axi_araddr[BYTE_BITS +: IDX_W];
          rd_cnt   <= s_axi_arlen;
          rd_state <= R_FETCH;
        end
        R_FETCH: rd_state <= R_DATA;
        R_DATA: if (r_fire) begin
          if (rd_cnt == 8'd0) begin
            rd_state <= R_IDLE;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
            rd_cnt <= rd_cnt - 8'd1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  axis_slave_ram_bram #(
    .DW    (C_S_AXI_DATA_WIDTH),
    .DEPTH (C_MEM_DEPTH),
    .IW    (IDX_W)
  ) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_fire),
    .waddr (wr_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (s_axi_rdata)
  );

endmodule

// File: tb/tb_axis_slave_ram.sv
// Directed testbench for axis_slave_ram.
// Inputs are driven, and outputs sampled, 1 ns after each rising clock edge.
module tb_axis_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic        wlast_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] wbuf    [256];
  logic [31:0] exp_buf [256];

  axis_slave_ram dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .wlast_err     (wlast_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Burst of len+1 beats taken from wbuf; wlast is driven on beat wlast_at.
  task automatic write_burst(input string tag, input logic [31:0] addr, input int len,
                             input logic [3:0] strb, input int wlast_at);
    int n;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len[7:0];
    s_axi_awvalid = 1'b1;
    check({tag, " awready"}, {31'd0, s_axi_awready}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wbuf[i];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (i == wlast_at);
      n = 0;
      while (!s_axi_wready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) check({tag, " wready timeout"}, {31'd0, s_axi_wready}, 32'd1);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check({tag, " bvalid after last beat"}, {31'd0, s_axi_bvalid}, 32'd1);
    tick();
    check({tag, " bvalid held"}, {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check({tag, " bvalid after b fire"}, {31'd0, s_axi_bvalid}, 32'd0);
  endtask

  // Burst of len+1 beats compared against exp_buf; with stall set,
  // rready toggles pseudo-randomly.
  task automatic read_burst(input string tag, input logic [31:0] addr, input int len,
                            input bit stall);
    int          beats, bad_data, bad_last, bad_stall, n;
    logic        held, hl;
    logic [31:0] hd;
    beats = 0; bad_data = 0; bad_last = 0; bad_stall = 0; n = 0;
    held = 1'b0; hl = 1'b0; hd = '0;
    s_axi_araddr  = addr;
    s_axi_arlen   = len[7:0];
    s_axi_arvalid = 1'b1;
    check({tag, " arready"}, {31'd0, s_axi_arready}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check({tag, " rvalid at k+1"}, {31'd0, s_axi_rvalid}, 32'd0);
    tick();
    check({tag, " rvalid at k+2"}, {31'd0, s_axi_rvalid}, 32'd1);
    while (beats <= len && n < 4000) begin
      if (held && (s_axi_rdata !== hd || s_axi_rlast !== hl || s_axi_rvalid !== 1'b1))
        bad_stall++;
      s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held = s_axi_rvalid && !s_axi_rready;
      hd   = s_axi_rdata;
      hl   = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        if (s_axi_rdata !== exp_buf[beats]) bad_data++;
        if (s_axi_rlast !== (beats == len)) bad_last++;
        beats++;
      end
      tick();
      n++;
    end
    s_axi_rready = 1'b0;
    check({tag, " beat count"},       beats,     len + 1);
    check({tag, " data mismatches"},  bad_data,  0);
    check({tag, " rlast errors"},     bad_last,  0);
    check({tag, " stall changes"},    bad_stall, 0);
    check({tag, " rvalid after end"}, {31'd0, s_axi_rvalid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awlen = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arlen = 0;
    s_axi_rready = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("reset awready",   {31'd0, s_axi_awready}, 32'd1);
    check("reset arready",   {31'd0, s_axi_arready}, 32'd1);
    check("reset wready",    {31'd0, s_axi_wready},  32'd0);
    check("reset bvalid",    {31'd0, s_axi_bvalid},  32'd0);
    check("reset rvalid",    {31'd0, s_axi_rvalid},  32'd0);
    check("reset rlast",     {31'd0, s_axi_rlast},   32'd0);
    check("reset wlast_err", {31'd0, wlast_err},     32'd0);
    check("reset rdata",     s_axi_rdata,            32'd0);

    // wvalid with no AW accepted: no W beat is taken
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'hDEAD_BEEF;
    s_axi_wstrb  = 4'hF;
    check("early w wready", {31'd0, s_axi_wready}, 32'd0);
    tick();
    check("early w wready later", {31'd0, s_axi_wready}, 32'd0);
    s_axi_wvalid = 1'b0;

    // Basic 4-beat write, then read back
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    write_burst("wr0x10", 32'h10, 3, 4'hF, 3);
    check("wlast_err after clean burst", {31'd0, wlast_err}, 32'd0);
    exp_buf[0] = 32'hA0; exp_buf[1] = 32'hA1; exp_buf[2] = 32'hA2; exp_buf[3] = 32'hA3;
    read_burst("rd0x10", 32'h10, 3, 1'b0);

    // Byte strobes: clearing lanes 0 and 2 of an all-ones word gives 0xFF00FF00
    wbuf[0] = 32'hFFFF_FFFF;
    write_burst("strb full", 32'h40, 0, 4'hF, 0);
    wbuf[0] = 32'h0000_0000;
    write_burst("strb 0x5", 32'h40, 0, 4'h5, 0);
    exp_buf[0] = 32'hFF00_FF00;
    read_burst("strb read", 32'h40, 0, 1'b0);

    // 256-beat burst, read back with rready toggling
    for (int i = 0; i < 256; i++) begin
      wbuf[i]    = 32'hC0DE_0000 + i;
      exp_buf[i] = 32'hC0DE_0000 + i;
    end
    write_burst("fill256", 32'h1000, 255, 4'hF, 255);
    read_burst("rd256 stall", 32'h1000, 255, 1'b1);

    // wlast on beat 1 of a 4-beat burst: flag set, all 4 beats taken, one B
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0BAD_0000 + i;
    write_burst("early wlast", 32'h200, 3, 4'hF, 1);
    check("wlast_err set", {31'd0, wlast_err}, 32'd1);
    for (int i = 0; i < 4; i++) exp_buf[i] = 32'h0BAD_0000 + i;
    read_burst("early wlast read", 32'h200, 3, 1'b0);

    // Wrap from the last word (index 4095) to word 0, plus aliasing of the upper address bits
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    write_burst("wrap", 32'h3FFC, 1, 4'hF, 1);
    exp_buf[0] = 32'h1111_1111; exp_buf[1] = 32'h2222_2222;
    read_burst("wrap read", 32'h3FFC, 1, 1'b0);
    exp_buf[0] = 32'h2222_2222;
    read_burst("word0 read", 32'h0, 0, 1'b0);
    read_burst("alias read", 32'h4000, 0, 1'b0);
    check("wlast_err sticky", {31'd0, wlast_err}, 32'd1);

    // Reset in the middle of a 16-beat read and a 4-beat write
    s_axi_araddr = 32'h1000; s_axi_arlen = 8'd15; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 32'h2000; s_axi_awlen = 8'd3;  s_axi_awvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h5555_0000; s_axi_wstrb = 4'hF;
    s_axi_rready = 1'b1;
    tick();
    s_axi_wdata = 32'h5555_0001;
    tick();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid read beat5 rdata", s_axi_rdata, 32'hC0DE_0005);
    check("mid write wready", {31'd0, s_axi_wready}, 32'd1);
    rst = 1'b0;
    tick();
    check("mid reset rvalid",    {31'd0, s_axi_rvalid},  32'd0);
    check("mid reset wready",    {31'd0, s_axi_wready},  32'd0);
    check("mid reset bvalid",    {31'd0, s_axi_bvalid},  32'd0);
    check("mid reset awready",   {31'd0, s_axi_awready}, 32'd1);
    check("mid reset arready",   {31'd0, s_axi_arready}, 32'd1);
    check("mid reset rlast",     {31'd0, s_axi_rlast},   32'd0);
    check("mid reset rdata",     s_axi_rdata,            32'd0);
    check("mid reset wlast_err", {31'd0, wlast_err},     32'd0);
    rst = 1'b1;
    s_axi_rready = 1'b0;
    tick();

    // New bursts work after reset; the two beats written before it are kept
    wbuf[0] = 32'h7777_7777;
    write_burst("post reset wr", 32'h2008, 0, 4'hF, 0);
    exp_buf[0] = 32'h5555_0000; exp_buf[1] = 32'h5555_0001; exp_buf[2] = 32'h7777_7777;
    read_burst("post reset rd", 32'h2000, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
